// File: rtl/eeprom_arbiter.sv
// Two-port arbiter/sequencer in front of the I2C EEPROM engine.
// Port 0 is the CPU side, port 1 the display-refresh side. One transaction is
// in flight at a time; the winner gets a one-cycle ACK (with ERR on timeout).
module eeprom_arbiter #(
    parameter logic [7:0]  WRITE_CTRL = 8'hA0,
    parameter logic [7:0]  READ_CTRL  = 8'hA1,
    parameter int unsigned TWR_CYCLES = 250000,
    parameter int unsigned TIMEOUT    = 131072
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       WE0,
    input  logic       WE1,
    input  logic [3:0] ADDR0,
    input  logic [3:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       ACK0,
    output logic       ACK1,
    output logic       ERR0,
    output logic       ERR1,
    output logic [7:0] RDATA0,
    output logic [7:0] RDATA1,
    output logic       BUSY,
    output logic [7:0] E_I2C_ADDR,
    output logic [3:0] E_WORD_ADDR,
    output logic [7:0] E_WDATA,
    output logic       E_GO,
    input  logic       E_DONE,
    input  logic [7:0] E_RDATA
);

    localparam int unsigned CNT_MAX = (TWR_CYCLES > TIMEOUT) ? TWR_CYCLES : TIMEOUT;
    localparam int unsigned CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TWR_LAST     = CW'(TWR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StWrWait} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          done_q, done_rise;
    logic          rr_q;      // last granted port; also owner of the current transaction
    logic          we_q;
    logic          grant, gnt_port;
    logic          ack_set, err_set, rd_cap;

    // Next-state, counter and grant decode
    always_comb begin
        done_rise = E_DONE & ~done_q;
        state_d   = state_q;
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        gnt_port  = rr_q;
        ack_set   = 1'b0;
        err_set   = 1'b0;
        rd_cap    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (REQ0 | REQ1) begin
                    grant    = 1'b1;
                    // On a tie the port that did not win last time goes first
                    gnt_port = (REQ0 & REQ1) ? ~rr_q : REQ1;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_inc;
                if (done_rise) begin
                    if (we_q) begin
                        cnt_d   = '0;
                        state_d = StWrWait;
                    end else begin
                        rd_cap  = 1'b1;
                        ack_set = 1'b1;
                        state_d = StIdle;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    ack_set = 1'b1;
                    err_set = 1'b1;
                    state_d = StIdle;
                end
            end
            StWrWait: begin
                cnt_d = cnt_inc;
                if (cnt_q == TWR_LAST) begin
                    ack_set = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        BUSY = (state_q != StIdle);
        E_GO = (state_q == StBusy);
    end

    // State, counter and DONE edge-detect registers
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= E_DONE;
        end
    end

    // Engine command latch, port responses and round-robin pointer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rr_q        <= 1'b1;
            we_q        <= 1'b0;
            E_I2C_ADDR  <= READ_CTRL;
            E_WORD_ADDR <= '0;
            E_WDATA     <= '0;
            ACK0        <= 1'b0;
            ACK1        <= 1'b0;
            ERR0        <= 1'b0;
            ERR1        <= 1'b0;
            RDATA0      <= '0;
            RDATA1      <= '0;
        end else begin
            if (grant) begin
                rr_q        <= gnt_port;
                we_q        <= gnt_port ? WE1 : WE0;
                E_I2C_ADDR  <= (gnt_port ? WE1 : WE0) ? WRITE_CTRL : READ_CTRL;
                E_WORD_ADDR <= gnt_port ? ADDR1 : ADDR0;
                E_WDATA     <= gnt_port ? WDATA1 : WDATA0;
            end
            ACK0 <= ack_set & ~rr_q;
            ACK1 <= ack_set & rr_q;
            ERR0 <= err_set & ~rr_q;
            ERR1 <= err_set & rr_q;
            if (rd_cap && !rr_q) RDATA0 <= E_RDATA;
            if (rd_cap && rr_q)  RDATA1 <= E_RDATA;
        end
    end

endmodule

// File: tb/tb_eeprom_arbiter.sv
// Scoreboard bench for eeprom_arbiter: stimulus pushes expected ACK responses,
// a negedge monitor pops and compares them whenever an ACK appears.
module tb_eeprom_arbiter;

    localparam int unsigned TWR = 100;
    localparam int unsigned TMO = 4096;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       REQ0, REQ1, WE0, WE1;
    logic [3:0] ADDR0, ADDR1;
    logic [7:0] WDATA0, WDATA1;
    logic       ACK0, ACK1, ERR0, ERR1;
    logic [7:0] RDATA0, RDATA1;
    logic       BUSY;
    logic [7:0] E_I2C_ADDR;
    logic [3:0] E_WORD_ADDR;
    logic [7:0] E_WDATA;
    logic       E_GO;
    logic       E_DONE;
    logic [7:0] E_RDATA;

    eeprom_arbiter #(
        .WRITE_CTRL (8'hA0),
        .READ_CTRL  (8'hA1),
        .TWR_CYCLES (TWR),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .REQ0        (REQ0),
        .REQ1        (REQ1),
        .WE0         (WE0),
        .WE1         (WE1),
        .ADDR0       (ADDR0),
        .ADDR1       (ADDR1),
        .WDATA0      (WDATA0),
        .WDATA1      (WDATA1),
        .ACK0        (ACK0),
        .ACK1        (ACK1),
        .ERR0        (ERR0),
        .ERR1        (ERR1),
        .RDATA0      (RDATA0),
        .RDATA1      (RDATA1),
        .BUSY        (BUSY),
        .E_I2C_ADDR  (E_I2C_ADDR),
        .E_WORD_ADDR (E_WORD_ADDR),
        .E_WDATA     (E_WDATA),
        .E_GO        (E_GO),
        .E_DONE      (E_DONE),
        .E_RDATA     (E_RDATA)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic       port;
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acks = 0;
    int   last_ack_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_acks(input string name, input int target, input int budget);
        int b;
        b = budget;
        while (n_acks < target && b > 0) begin
            @(posedge CLK);
            b--;
        end
        #1;
        check({name, "_ack_arrived"}, n_acks, target);
    endtask

    // Engine model
    logic       eng_en = 1'b0;
    logic       eng_addr_mode = 1'b0;
    int         eng_delay = 10;
    int         eng_hold = 1;
    logic [7:0] eng_data = 8'h00;
    int         done_cyc = 0;
    int         kick_req = 0;
    int         kick_done = 0;

    initial begin
        E_DONE  = 1'b0;
        E_RDATA = 8'h00;
        forever begin
            @(posedge CLK);
            #1;
            if (kick_req != kick_done) begin
                // Stale DONE pulse with no transaction outstanding
                kick_done = kick_req;
                E_DONE = 1'b1;
                repeat (3) @(posedge CLK);
                #1;
                E_DONE = 1'b0;
            end else if (eng_en && E_GO) begin
                repeat (eng_delay - 1) @(posedge CLK);
                #1;
                E_RDATA  = eng_addr_mode ? {4'hA, E_WORD_ADDR} : eng_data;
                E_DONE   = 1'b1;
                done_cyc = cyc;
                repeat (eng_hold) @(posedge CLK);
                #1;
                E_DONE = 1'b0;
            end
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (ACK0 || ACK1) begin
                n_acks++;
                last_ack_cyc = cyc;
                check("ack_overlap", {31'b0, ACK0 & ACK1}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_unexpected: got ACK0=%0b ACK1=%0b expected none", ACK0, ACK1);
                end else begin
                    e = sb.pop_front();
                    check("ack_port", {31'b0, ACK1}, {31'b0, e.port});
                    check("ack_err", {31'b0, (ACK1 ? ERR1 : ERR0)}, {31'b0, e.err});
                    check("ack_rdata", {24'b0, (ACK1 ? RDATA1 : RDATA0)}, {24'b0, e.rdata});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;
        int r;
        int budget;

        RESET_N = 1'b0;
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = 0; ADDR1 = 0; WDATA0 = 0; WDATA1 = 0;
        tick(3);
        check("rst_ack_err", {28'b0, ACK0, ACK1, ERR0, ERR1}, 32'd0);
        check("rst_rdata", {16'b0, RDATA0, RDATA1}, 32'd0);
        check("rst_i2c_addr", {24'b0, E_I2C_ADDR}, 32'hA1);
        check("rst_busy_go", {30'b0, BUSY, E_GO}, 32'd0);
        check("rst_eaddr_wdata", {20'b0, E_WORD_ADDR, E_WDATA}, 32'd0);
        RESET_N = 1'b1;
        tick(2);

        // 1: port 0 read, engine answers 8'h5A after 2048 cycles
        eng_en = 1; eng_addr_mode = 0; eng_data = 8'h5A; eng_delay = 2048; eng_hold = 1;
        REQ0 = 1; WE0 = 0; ADDR0 = 4'h3;
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 8'h5A});
        tick(1);
        REQ0 = 0;
        check("t1_i2c_addr", {24'b0, E_I2C_ADDR}, 32'hA1);
        check("t1_word_addr", {28'b0, E_WORD_ADDR}, 32'h3);
        check("t1_go_busy", {30'b0, BUSY, E_GO}, 32'd3);
        tick(1000);
        check("t1_go_held", {31'b0, E_GO}, 32'd1);
        wait_acks("t1", 1, 3000);
        check("t1_ack_latency", last_ack_cyc - done_cyc, 32'd1);
        tick(1);
        check("t1_idle_go_busy", {30'b0, BUSY, E_GO}, 32'd0);
        check("t1_word_addr_hold", {28'b0, E_WORD_ADDR}, 32'h3);
        check("t1_rdata0", {24'b0, RDATA0}, 32'h5A);

        // 2: port 1 write, ACK one write-cycle time after the registered DONE edge
        eng_delay = 20;
        REQ1 = 1; WE1 = 1; ADDR1 = 4'h7; WDATA1 = 8'hC3;
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: 8'h00});
        tick(1);
        REQ1 = 0;   // dropped after grant: must still complete
        check("t2_i2c_addr", {24'b0, E_I2C_ADDR}, 32'hA0);
        check("t2_wdata", {24'b0, E_WDATA}, 32'hC3);
        check("t2_word_addr", {28'b0, E_WORD_ADDR}, 32'h7);
        tick(25);
        check("t2_wrwait_busy_go", {30'b0, BUSY, E_GO}, 32'd2);
        wait_acks("t2", 2, 400);
        // The DUT registers the rise one edge after done_cyc
        check("t2_twr_latency", last_ack_cyc - (done_cyc + 1), TWR);

        // 3: both ports requesting continuously, grants alternate starting at port 0
        eng_addr_mode = 1; eng_delay = 10;
        WE0 = 0; WE1 = 0; ADDR0 = 4'h1; ADDR1 = 4'h2;
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 8'hA1});
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: 8'hA2});
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 8'hA1});
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: 8'hA2});
        REQ0 = 1; REQ1 = 1;
        k = 0;
        budget = 500;
        while (k < 4 && budget > 0) begin
            @(negedge CLK);
            budget--;
            if (ACK0 || ACK1) k++;
        end
        REQ0 = 0; REQ1 = 0;
        check("t3_ack_count", k, 32'd4);
        tick(20);
        check("t3_no_fifth_grant", {31'b0, BUSY}, 32'd0);
        base = n_acks;

        // 4: engine silent, port 0 read times out
        eng_en = 0;
        REQ0 = 1; WE0 = 0; ADDR0 = 4'h5;
        r = cyc;
        sb.push_back('{port: 1'b0, err: 1'b1, rdata: 8'hA1});
        tick(1);
        REQ0 = 0;
        wait_acks("t4", base + 1, TMO + 50);
        check("t4_timeout_latency", last_ack_cyc - r, TMO + 1);
        tick(1);
        check("t4_busy_fell", {31'b0, BUSY}, 32'd0);

        // 5: reset in the middle of BUSY, then a normal read
        REQ0 = 1; WE0 = 0; ADDR0 = 4'h6;
        tick(1);
        REQ0 = 0;
        tick(10);
        check("t5_busy_before_rst", {31'b0, BUSY}, 32'd1);
        RESET_N = 1'b0;
        #1;
        check("t5_rst_go_busy", {30'b0, BUSY, E_GO}, 32'd0);
        check("t5_rst_i2c_addr", {24'b0, E_I2C_ADDR}, 32'hA1);
        check("t5_rst_rdata0", {24'b0, RDATA0}, 32'd0);
        base = n_acks;
        tick(3);
        RESET_N = 1'b1;
        tick(5);
        check("t5_no_ack", n_acks, base);
        eng_en = 1; eng_addr_mode = 0; eng_data = 8'h5A; eng_delay = 10;
        REQ0 = 1; WE0 = 0; ADDR0 = 4'h3;
        sb.push_back('{port: 1'b0, err: 1'b0, rdata: 8'h5A});
        tick(1);
        REQ0 = 0;
        wait_acks("t5", base + 1, 100);

        // 6: DONE held high for 1024 cycles gives one ACK; stale DONE while idle gives none
        base = n_acks;
        eng_data = 8'h3C; eng_hold = 1024;
        REQ1 = 1; WE1 = 0; ADDR1 = 4'h9;
        sb.push_back('{port: 1'b1, err: 1'b0, rdata: 8'h3C});
        tick(1);
        REQ1 = 0;
        wait_acks("t6", base + 1, 200);
        tick(1100);
        check("t6_single_ack", n_acks, base + 1);
        kick_req = kick_req + 1;
        tick(10);
        check("t6_stale_done_no_ack", n_acks, base + 1);
        check("t6_stale_done_idle", {31'b0, BUSY}, 32'd0);

        tick(5);
        check("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
